// File: rtl/uncache_agent.sv
// Uncached access agent: buffers uncached stores in a small FIFO and serialises
// stores and loads into single outstanding requests toward axi_ctrl.
module uncache_agent #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        unrd_req,
  output logic [31:0] unrd_addr,
  output logic        unwr_req,
  output logic [3:0]  unwr_wstrb,
  output logic [31:0] unwr_addr,
  output logic [31:0] unwr_data,
  input  logic        un_reload,
  input  logic [31:0] unrd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WR, RD, GAP} state_t;

  entry_t          fifo_mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW:0]     count;
  state_t          state;
  logic            load_pending;

  logic            is_store;
  logic            store_ok;
  logic            load_ok;
  logic            push;
  logic            pop;
  logic            load_acc;
  entry_t          new_entry;
  entry_t          head_entry;

  assign is_store   = (req_wstrb != 4'b0000);
  assign store_ok   = (count < DEPTH_C);
  assign load_ok    = (count == '0) && (state == IDLE) && !load_pending;
  // Readiness is a function of registered state and the access type only, so
  // the pipeline can sample it without a combinational loop through req_valid.
  assign req_ready  = is_store ? store_ok : load_ok;

  assign push       = req_valid && req_ready && is_store;
  assign load_acc   = req_valid && req_ready && !is_store;
  assign pop        = un_reload && (state == WR);

  assign new_entry  = '{addr: req_addr, wstrb: req_wstrb, data: req_wdata};
  assign head_entry = fifo_mem[head];

  assign busy = (count != '0) || (state != IDLE) || load_pending;

  // NOTE: the storage array carries no reset; head/tail/count define which
  // entries are valid, so stale contents are never observed after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail] <= new_entry;
    end
  end

  // NOTE: every register here uses <= so all updates see pre-edge values and
  // the push/pop bookkeeping and the state transition stay mutually consistent.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      load_pending <= 1'b0;
      unwr_req     <= 1'b0;
      unwr_addr    <= '0;
      unwr_wstrb   <= '0;
      unwr_data    <= '0;
      unrd_req     <= 1'b0;
      unrd_addr    <= '0;
      rdata        <= '0;
      rdata_valid  <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;

      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase

      if (load_acc) begin
        load_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (count != '0) begin
            state      <= WR;
            unwr_req   <= 1'b1;
            unwr_addr  <= head_entry.addr;
            unwr_wstrb <= head_entry.wstrb;
            unwr_data  <= head_entry.data;
          end else if (push) begin
            // Empty FIFO: the entry being written is the head, so bypass the
            // array and issue it straight from the request.
            state      <= WR;
            unwr_req   <= 1'b1;
            unwr_addr  <= new_entry.addr;
            unwr_wstrb <= new_entry.wstrb;
            unwr_data  <= new_entry.data;
          end else if (load_acc || load_pending) begin
            state    <= RD;
            unrd_req <= 1'b1;
            if (load_acc) begin
              unrd_addr <= req_addr;
            end
          end
        end
        WR: begin
          if (un_reload) begin
            unwr_req <= 1'b0;
            state    <= GAP;
          end
        end
        RD: begin
          if (un_reload) begin
            unrd_req     <= 1'b0;
            rdata        <= unrd_data;
            rdata_valid  <= 1'b1;
            load_pending <= 1'b0;
            state        <= GAP;
          end
        end
        GAP: begin
          // Keeps both requests low long enough for axi_ctrl to resample.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uncache_agent.sv
// Bench for uncache_agent: transaction-level reference model (store queue plus
// outstanding-transaction timing) compared every cycle, plus directed scenarios.
module tb_uncache_agent;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [3:0]  req_wstrb;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        busy;
  logic        unrd_req;
  logic [31:0] unrd_addr;
  logic        unwr_req;
  logic [3:0]  unwr_wstrb;
  logic [31:0] unwr_addr;
  logic [31:0] unwr_data;
  logic        un_reload;
  logic [31:0] unrd_data;

  uncache_agent #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_wstrb(req_wstrb), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rdata_valid(rdata_valid), .rdata(rdata), .busy(busy),
    .unrd_req(unrd_req), .unrd_addr(unrd_addr),
    .unwr_req(unwr_req), .unwr_wstrb(unwr_wstrb), .unwr_addr(unwr_addr),
    .unwr_data(unwr_data), .un_reload(un_reload), .unrd_data(unrd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] data;
  } st_t;

  st_t         mq[$];          // stores accepted but not yet completed
  int          m_cur;          // 0 none, 1 write outstanding, 2 read outstanding
  int          m_gap;          // dead cycles still owed after a completion
  st_t         m_wr;
  logic [31:0] m_rd_addr;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  bit          started = 0;
  logic        m_acc;
  logic        m_is_st;
  st_t         m_new;

  function automatic logic m_idle();
    return (m_cur == 0) && (m_gap == 0);
  endfunction

  function automatic logic m_ready();
    if (req_wstrb != 4'b0000) return mq.size() < DEPTH;
    return (mq.size() == 0) && m_idle();
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      mq.delete();
      m_cur = 0; m_gap = 0;
      m_wr = '{32'h0, 4'h0, 32'h0};
      m_rd_addr = '0; m_rvalid = 1'b0; m_rdata = '0;
    end else begin
      m_acc   = req_valid && m_ready();
      m_is_st = (req_wstrb != 4'b0000);
      m_new   = '{req_addr, req_wstrb, req_wdata};
      m_rvalid = 1'b0;
      if (m_cur == 1 && un_reload) begin
        void'(mq.pop_front());
        m_cur = 0; m_gap = 1;
      end else if (m_cur == 2 && un_reload) begin
        m_rdata = unrd_data; m_rvalid = 1'b1;
        m_cur = 0; m_gap = 1;
      end else if (m_cur == 0 && m_gap > 0) begin
        m_gap--;
      end else if (m_cur == 0) begin
        if (mq.size() > 0) begin
          m_cur = 1; m_wr = mq[0];
        end else if (m_acc && m_is_st) begin
          m_cur = 1; m_wr = m_new;
        end else if (m_acc) begin
          m_cur = 2; m_rd_addr = req_addr;
        end
      end
      if (m_acc && m_is_st) mq.push_back(m_new);
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("unwr_req",    unwr_req,    32'(m_cur == 1));
      check("unwr_addr",   unwr_addr,   m_wr.addr);
      check("unwr_wstrb",  unwr_wstrb,  32'(m_wr.wstrb));
      check("unwr_data",   unwr_data,   m_wr.data);
      check("unrd_req",    unrd_req,    32'(m_cur == 2));
      check("unrd_addr",   unrd_addr,   m_rd_addr);
      check("rdata_valid", rdata_valid, 32'(m_rvalid));
      check("rdata",       rdata,       m_rdata);
      check("req_ready",   req_ready,   32'(m_ready()));
      check("busy",        busy,        32'((mq.size() != 0) || !m_idle()));
      check("req_excl",    unwr_req & unrd_req, 32'h0);
    end
  end

  // Issued write data in order, for the program-order check.
  logic [31:0] issued[$];
  logic        prev_wr = 1'b0;
  always @(negedge clk) begin
    if (unwr_req === 1'b1 && !prev_wr) issued.push_back(unwr_data);
    prev_wr = (unwr_req === 1'b1);
  end

  // ---------------- axi_ctrl responder ----------------
  bit          resp_en = 0;
  bit          resp_rand = 1;
  logic [31:0] resp_word = '0;
  int          resp_delay = 1;
  int          resp_cnt = 0;
  int          dmin = 1;
  int          dmax = 8;

  always begin
    @(posedge clk); #1;
    if (resp_en) begin
      un_reload = 1'b0;
      if (unwr_req || unrd_req) begin
        if (resp_cnt >= resp_delay) begin
          un_reload = 1'b1;
          unrd_data = resp_rand ? $urandom : resp_word;
          resp_cnt = 0;
          resp_delay = $urandom_range(dmax, dmin);
        end else begin
          resp_cnt++;
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic acc = 1'b0;
    req_valid = 1'b1; req_addr = a; req_wstrb = s; req_wdata = d;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
    end
    check("send_accepted", acc, 1);
    req_valid = 1'b0; req_wstrb = 4'b0000;
  endtask

  task automatic wait_idle();
    logic idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(negedge clk);
      idle = !busy && !unwr_req && !unrd_req;
    end
    check("idle_reached", idle, 1);
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1000000;
    check("global_timeout", 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  logic [31:0] pushed[$];
  logic        seen;
  logic [3:0]  ws;

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_wstrb = 4'b0000;
    req_addr = '0; req_wdata = '0; un_reload = 1'b0; unrd_data = '0;
    cycles(2);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_busy",  busy, 0);
    check("rst_unwr",  unwr_req, 0);
    @(posedge clk); #1;

    // Single store with a 5-cycle completion delay.
    resp_rand = 0; resp_word = 32'h0; dmin = 5; dmax = 5;
    resp_delay = 5; resp_cnt = 0; resp_en = 1;
    send(32'hBFAF_F000, 4'b1111, 32'h1234_5678);
    @(negedge clk);
    check("t1_unwr_req",   unwr_req, 1);
    check("t1_unwr_addr",  unwr_addr, 32'hBFAF_F000);
    check("t1_unwr_wstrb", unwr_wstrb, 32'hF);
    check("t1_unwr_data",  unwr_data, 32'h1234_5678);
    @(posedge clk); #1;
    wait_idle();

    // Fill the FIFO while the first write is held, then stall a fifth store.
    resp_en = 0; un_reload = 1'b0; issued.delete();
    for (int i = 0; i < 4; i++) send(32'hA000_0000 + 32'(i*4), 4'b1111, 32'h5500_0000 + 32'(i));
    req_valid = 1'b1; req_wstrb = 4'b0011; req_addr = 32'hA000_0010; req_wdata = 32'h5500_0004;
    @(negedge clk);
    check("t2_full_ready", req_ready, 0);
    @(posedge clk); #1;
    dmin = 1; dmax = 3; resp_delay = 2; resp_cnt = 0; resp_en = 1;
    send(32'hA000_0010, 4'b0011, 32'h5500_0004);
    wait_idle();
    check("t2_issue_count", issued.size(), 5);
    for (int i = 0; i < 5 && i < issued.size(); i++)
      check("t2_issue_order", issued[i], 32'h5500_0000 + 32'(i));

    // Load behind a store returns fixed data.
    resp_word = 32'hDEAD_BEEF; dmin = 3; dmax = 3;
    send(32'hBFAF_F008, 4'b0100, 32'h00AB_0000);
    send(32'hBFAF_F004, 4'b0000, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); seen = rdata_valid;
      if (!seen) begin @(posedge clk); #1; end
    end
    check("t3_rvalid_seen", seen, 1);
    check("t3_rdata", rdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_rvalid_once", rdata_valid, 0);
      check("t3_rdata_hold", rdata, 32'hDEAD_BEEF);
    end
    @(posedge clk); #1;
    wait_idle();

    // Pointer wrap: ten stores, random completion delays.
    resp_rand = 1; dmin = 1; dmax = 8; issued.delete(); pushed.delete();
    for (int i = 0; i < 10; i++) begin
      pushed.push_back(32'hC0DE_0000 + 32'(i * 17));
      send(32'hB000_0000 + 32'(i * 4), 4'b1111, pushed[i]);
    end
    wait_idle();
    check("t4_issue_count", issued.size(), 10);
    for (int i = 0; i < 10 && i < issued.size(); i++)
      check("t4_issue_order", issued[i], pushed[i]);

    // Reset mid-transaction with three stores buffered.
    resp_en = 0; un_reload = 1'b0;
    for (int i = 0; i < 3; i++) send(32'hD000_0000 + 32'(i*4), 4'b1111, 32'hEE00_0000 + 32'(i));
    @(negedge clk);
    check("t5_unwr_before", unwr_req, 1);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("t5_ready", req_ready, 1);
    check("t5_busy", busy, 0);
    check("t5_unwr", unwr_req, 0);
    check("t5_unwr_data", unwr_data, 0);
    @(posedge clk); #1;
    issued.delete(); resp_cnt = 0; resp_en = 1;
    cycles(12);
    check("t5_no_stale_write", issued.size(), 0);

    // Spurious completion while idle.
    resp_en = 0;
    un_reload = 1'b1; unrd_data = 32'h1357_9BDF;
    cycles(1);
    un_reload = 1'b0;
    @(negedge clk);
    check("t6_no_rvalid", rdata_valid, 0);
    check("t6_busy", busy, 0);
    @(posedge clk); #1;

    // Randomized mix of stores and loads.
    resp_rand = 1; dmin = 1; dmax = 8; resp_cnt = 0; resp_en = 1;
    for (int i = 0; i < 150; i++) begin
      cycles($urandom_range(2, 0));
      ws = ($urandom_range(9, 0) < 7) ? 4'($urandom_range(15, 1)) : 4'b0000;
      send($urandom, ws, $urandom);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uncache_agent.md
# uncache_agent

Uncached-access agent between the pipeline's uncached data port and `axi_ctrl`'s `unrd_*`/`unwr_*` request interface. It buffers uncached stores in a FIFO of depth `DEPTH`. Stores are issued one at a time in program order. An uncached load is issued only after all older stores have drained, and its data is returned with a one-cycle valid pulse. At most one request is outstanding toward `axi_ctrl`.

## Interface
- `DEPTH`, 4: store FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all state updates on posedge.
- `resetn` in 1: synchronous, active-low reset.
- `req_valid` in 1: pipeline presents an uncached access.
- `req_wstrb` in 4: byte enables; `4'b0000` = load, nonzero = store.
- `req_addr` in 32: access address.
- `req_wdata` in 32: store data (ignored for loads).
- `req_ready` out 1: access accepted on a cycle with `req_valid & req_ready`; combinational.
- `rdata_valid` out 1: one-cycle pulse, load data valid.
- `rdata` out 32: load data; held until next load completes.
- `busy` out 1: FIFO non-empty, or FSM not IDLE, or load pending.
- `unrd_req` out 1: uncached read request to `axi_ctrl`; level.
- `unrd_addr` out 32: read address.
- `unwr_req` out 1: uncached write request; level.
- `unwr_wstrb` out 4: write strobes.
- `unwr_addr` out 32: write address.
- `unwr_data` out 32: write data.
- `un_reload` in 1: one-cycle completion pulse from `axi_ctrl`.
- `unrd_data` in 32: read data, valid in the `un_reload` cycle.

## Operation
- Store FIFO:
  - Entries are {addr, wstrb, data}.
  - Uses `log2(DEPTH)`-bit head/tail pointers that wrap modulo `DEPTH`, plus a `log2(DEPTH)+1`-bit count.
  - Push on accepted store. Pop on `un_reload` in state WR.
  - Simultaneous push and pop leave count unchanged.
- Acceptance rules:
  - A store is accepted when `count < DEPTH`, independent of FSM state.
  - A load is accepted only when `count == 0` and state is IDLE and no load is pending.
  - An accepted load latches its address and sets `load_pending`.
  - `req_ready` follows these rules and depends only on registered state, never on `req_valid`.
- FSM states:
  - IDLE: if `count != 0`, go to WR and register the FIFO head onto `unwr_addr`/`unwr_wstrb`/`unwr_data` with `unwr_req <= 1`. Else if a load is accepted this cycle or `load_pending` is set, go to RD with `unrd_addr <= load address` and `unrd_req <= 1`. Stores take priority over loads.
  - WR: hold all `unwr_*` stable. On `un_reload`, set `unwr_req <= 0`, pop, and go to GAP.
  - RD: hold `unrd_*` stable. On `un_reload`, set `unrd_req <= 0`, `rdata <= unrd_data`, `rdata_valid <= 1` (next cycle only), clear `load_pending`, and go to GAP.
  - GAP: one cycle, then IDLE. This guarantees the request is low for at least two cycles between transactions, which `axi_ctrl` requires to return to its sampling stage.
- Request invariants:
  - `unrd_req` and `unwr_req` are never both high.
  - Request payloads never change while the corresponding request is high.
- `unwr_wstrb` is passed through unmodified; `axi_ctrl` derives `awsize` from it.
- `un_reload` outside WR/RD is ignored.

## Timing
- Reset values:
  - `unrd_req`, `unwr_req`, `rdata_valid`: 0.
  - `rdata`, `unrd_addr`, `unwr_addr`, `unwr_data`: 0.
  - `unwr_wstrb`: 0.
  - `count`, head, tail, `load_pending`: 0.
  - State: IDLE. `req_ready` reads 1 after reset.
- Store accepted at edge E into an empty FIFO with FSM in IDLE: `unwr_req` is high from E+1.
- `un_reload` high in cycle T:
  - Request low from T+1.
  - State GAP in T+1, IDLE in T+2.
  - Next request high from T+3 at earliest.
- Load: accepted at E, `unrd_req` high from E+1. With `un_reload` at T, `rdata_valid` pulses in T+1 with `rdata == unrd_data(T)`.
- Full FIFO: `req_ready = 0` for stores. A store presented in the same cycle as a pop is not accepted; it is accepted the following cycle.
- Load behind stores: `req_ready = 0` until the FIFO is empty and the FSM is IDLE. The load is then accepted and issued the next cycle.
- Reset asserted mid-transaction:
  - All state is cleared at that edge and requests drop.
  - FIFO contents are discarded.
  - `axi_ctrl` shares the reset, so no completion is awaited.

## Test plan
- Single store `addr=0xBFAF_F000`, `wstrb=4'b1111`, `data=0x1234_5678` → `unwr_req` high one cycle after accept with the exact payload. `un_reload` after 5 cycles → `unwr_req` low next cycle; `busy` low two cycles later.
- Four back-to-back stores (`DEPTH=4`) while the first is in WR → `req_ready` is 0 with count=4. A fifth store is stalled until the first `un_reload`. The four writes issue in order with ≥2 idle cycles between requests.
- Store `wstrb=4'b0100`, then load `0xBFAF_F004` → the load is stalled until the store completes. `unrd_req` is high only after GAP/IDLE. `un_reload` with `unrd_data=0xDEAD_BEEF` → `rdata_valid` pulses once, `rdata=0xDEAD_BEEF`, and `rdata` holds afterward.
- Pointer wrap: 10 stores with distinct data and random `un_reload` delays (1–8 cycles) → issued data sequence matches push order. `unrd_req & unwr_req` is never 1.
- Reset asserted while `unwr_req` is high with count=3 → next cycle all outputs are at reset values, `req_ready=1`, `busy=0`. No write from the old FIFO is issued after reset.
- Spurious `un_reload` in IDLE → no pop, no `rdata_valid`, count unchanged.
